// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter: FSM encodings and parameter defaults.
package period_meter_pkg;

  localparam int          PM_CNT_W_DEFAULT   = 32;
  localparam int unsigned PM_TIMEOUT_DEFAULT = 100_000_000;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input plus a registered copy for
// rising-edge detection on the synchronised level.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign o_level = s2;
  assign o_rise  = s2 & ~s3;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous signal in i_clk cycles,
// with a no-edge timeout that falls back to waiting for a fresh edge.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int          CNT_W   = PM_CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = PM_TIMEOUT_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi;
  logic             level;
  logic             rise;
  logic             vld_p1;

  sync_edge_detect u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_sig),
    .o_level (level),
    .o_rise  (rise)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      vld_p1    <= 1'b0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      // Stage p1 -> output: the result registers lead the valid pulse by one cycle.
      o_valid <= vld_p1 & i_enable;

      if (!i_enable) begin
        state     <= IDLE;
        cnt       <= '0;
        hi        <= '0;
        o_timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= '0;
            hi    <= '0;
          end
          ARM, MEASURE: begin
            // A rise on the last count still closes a measurement, so it wins over timeout.
            if (rise) begin
              state     <= MEASURE;
              cnt       <= '0;
              hi        <= CNT_ONE;
              o_timeout <= 1'b0;
              if (state == MEASURE) begin
                o_period <= cnt + CNT_ONE;
                o_high   <= hi;
                vld_p1   <= 1'b1;
              end
            end else if (cnt == CNT_LAST) begin
              state     <= ARM;
              cnt       <= '0;
              hi        <= '0;
              o_timeout <= 1'b1;
              o_period  <= '0;
              o_high    <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (state == MEASURE && level) begin
                hi <= hi + CNT_ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: an edge-history model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;
  localparam int HMAX    = 8192;

  logic             clk;
  logic             i_reset;
  logic             i_enable;
  logic             i_sig;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic             o_valid;
  logic             o_timeout;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_sig     (i_sig),
    .o_period  (o_period),
    .o_high    (o_high),
    .o_valid   (o_valid),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: sampled input history and the expected outputs after each edge.
  bit sig_hist [HMAX];
  int cyc       = 0;
  int rst_floor = 0;
  bit rst_hit   = 1'b0;
  bit active;
  bit have_ref;
  int ref_edge;
  int start;
  int valid_due;
  bit m_valid;
  bit m_tmo;
  int m_per;
  int m_hi;

  int n_valid  = 0;
  int last_per = 0;
  int last_hi  = 0;

  function automatic bit samp(int i);
    if (i < 0 || i < rst_floor) return 1'b0;
    return sig_hist[i];
  endfunction

  task automatic model_reset();
    active    = 1'b0;
    have_ref  = 1'b0;
    ref_edge  = 0;
    start     = 0;
    valid_due = -1;
    m_valid   = 1'b0;
    m_tmo     = 1'b0;
    m_per     = 0;
    m_hi      = 0;
  endtask

  // Edge k: the meter reacts to an input first sampled high two edges earlier.
  task automatic model_step(int k, bit en);
    bit rise;
    int cnt_hi;
    m_valid = (valid_due == k) && en;
    if (!en) begin
      active   = 1'b0;
      have_ref = 1'b0;
      m_tmo    = 1'b0;
    end else if (!active) begin
      active = 1'b1;
      start  = k;
    end else begin
      rise = samp(k - 2) && !samp(k - 3);
      if (rise) begin
        if (have_ref) begin
          cnt_hi = 0;
          for (int j = ref_edge; j < k; j++) cnt_hi += int'(samp(j - 2));
          m_per     = k - ref_edge;
          m_hi      = cnt_hi;
          valid_due = k + 1;
        end
        have_ref = 1'b1;
        ref_edge = k;
        start    = k;
        m_tmo    = 1'b0;
      end else if (k - start == TIMEOUT) begin
        m_tmo    = 1'b1;
        m_per    = 0;
        m_hi     = 0;
        have_ref = 1'b0;
        start    = k;
      end
    end
  endtask

  always @(negedge i_reset) rst_hit = 1'b1;

  always @(posedge clk) begin
    cyc++;
    if (cyc >= HMAX) begin
      bad++;
      $display("FAIL cycle_budget actual=%0d required<%0d", cyc, HMAX);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "cycle budget exhausted");
    end
    sig_hist[cyc] = i_sig;
    if (rst_hit || !i_reset) begin
      model_reset();
      rst_floor = i_reset ? cyc : cyc + 1;
      rst_hit   = 1'b0;
    end
    if (i_reset) model_step(cyc, i_enable);
    #1;
    check("o_valid",   32'(o_valid),   32'(m_valid));
    check("o_timeout", 32'(o_timeout), 32'(m_tmo));
    check("o_period",  32'(o_period),  m_per);
    check("o_high",    32'(o_high),    m_hi);
    if (o_valid === 1'b1) begin
      n_valid++;
      last_per = int'(o_period);
      last_hi  = int'(o_high);
    end
  end

  task automatic wave(int hi_c, int lo_c, int reps);
    for (int r = 0; r < reps; r++) begin
      i_sig = 1'b1;
      repeat (hi_c) @(negedge clk);
      i_sig = 1'b0;
      repeat (lo_c) @(negedge clk);
    end
  endtask

  int nv;

  initial begin
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_sig    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period",  32'(o_period),  0);
    check("rst_high",    32'(o_high),    0);
    check("rst_valid",   32'(o_valid),   0);
    check("rst_timeout", 32'(o_timeout), 0);
    i_reset = 1'b1;
    @(negedge clk);
    i_enable = 1'b1;
    repeat (3) @(negedge clk);

    // Square wave 100/30: five rises give four measurements.
    nv = n_valid;
    wave(30, 70, 5);
    check("sq_count",  n_valid - nv, 4);
    check("sq_period", last_per, 100);
    check("sq_high",   last_hi, 30);

    // Held low: timeout with zeroed results, then a rise clears it without a measurement.
    nv = n_valid;
    repeat (1000) @(negedge clk);
    check("tmo_flag",   32'(o_timeout), 1);
    check("tmo_period", 32'(o_period),  0);
    check("tmo_high",   32'(o_high),    0);
    check("tmo_novld",  n_valid - nv,   0);
    i_sig = 1'b1;
    repeat (5) @(negedge clk);
    check("tmo_clear", 32'(o_timeout), 0);
    check("tmo_rearm", n_valid - nv,   0);
    repeat (25) @(negedge clk);
    i_sig = 1'b0;
    repeat (70) @(negedge clk);

    // Minimum period 4 (2 high / 2 low); the first rise closes the 100-cycle period.
    nv = n_valid;
    wave(2, 2, 6);
    repeat (3) @(negedge clk);
    check("p4_count",  n_valid - nv, 6);
    check("p4_period", last_per, 4);
    check("p4_high",   last_hi, 2);

    // Enable dropped for one cycle mid-measure.
    wave(30, 70, 2);
    i_sig = 1'b1;
    repeat (10) @(negedge clk);
    i_enable = 1'b0;
    @(negedge clk);
    i_enable = 1'b1;
    check("dis_hold",  32'(o_period), 100);
    check("dis_novld", 32'(o_valid),  0);
    nv = n_valid;
    repeat (19) @(negedge clk);
    i_sig = 1'b0;
    repeat (70) @(negedge clk);
    wave(30, 70, 2);
    check("dis_count",  n_valid - nv, 1);
    check("dis_period", last_per, 100);

    // Asynchronous reset pulse between clock edges, mid-measure.
    i_sig = 1'b1;
    repeat (10) @(negedge clk);
    #2 i_reset = 1'b0;
    #1;
    check("arst_period",  32'(o_period),  0);
    check("arst_high",    32'(o_high),    0);
    check("arst_valid",   32'(o_valid),   0);
    check("arst_timeout", 32'(o_timeout), 0);
    #1 i_reset = 1'b1;
    @(negedge clk);
    nv = n_valid;
    repeat (19) @(negedge clk);
    i_sig = 1'b0;
    repeat (70) @(negedge clk);
    check("arst_novld", n_valid - nv, 0);

    // Period exactly TIMEOUT: the rise meets the last count and wins.
    wave(30, 970, 3);
    check("edge_period",  last_per, 1000);
    check("edge_high",    last_hi, 30);
    check("edge_timeout", 32'(o_timeout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, counter and result width.
REQ-002 SHALL have parameter TIMEOUT, default 100_000_000, i_clk cycles without a rising edge before timeout; TIMEOUT <= 2^CNT_W - 1.
REQ-003 SHALL have port i_clk  input  1  system clock (100 MHz); the sole clock.
REQ-004 SHALL have port i_reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_enable  input  1  measurement enable, synchronous to i_clk.
REQ-006 SHALL have port i_sig  input  1  slow signal to measure, asynchronous to i_clk (e.g. a divided clock).
REQ-007 SHALL have port o_period  output  CNT_W  i_clk cycles between consecutive i_sig rising edges.
REQ-008 SHALL have port o_high  output  CNT_W  i_clk cycles i_sig was high within that period.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse when o_period/o_high update.
REQ-010 SHALL have port o_timeout  output  1  level; no edge seen within TIMEOUT cycles.

Function
REQ-011 SHALL synchronise i_sig through two flip-flops (s1, s2) and register s2 into s3; rise = s2 & ~s3.
REQ-012 SHALL implement states IDLE, ARM, MEASURE.
REQ-013 SHALL move IDLE->ARM when i_enable=1.
REQ-014 SHALL move ARM->MEASURE on rise, loading cnt=0 and hi=1.
REQ-015 SHALL, in MEASURE without rise, increment cnt by 1 and increment hi when s2=1.
REQ-016 SHALL, in MEASURE on rise, register o_period=cnt+1 and o_high=hi, pulse o_valid next cycle, reload cnt=0 and hi=1, and stay in MEASURE.
REQ-017 SHALL raise o_timeout in ARM or MEASURE when cnt reaches TIMEOUT-1 without rise, set o_period=0 and o_high=0, and go to ARM; cnt also counts in ARM, from 0 on entry.
REQ-018 SHALL clear o_timeout on the next rise.
REQ-019 SHALL give rise priority over timeout when both occur in the same cycle; this produces a measurement and no timeout.
REQ-020 SHALL, when i_enable=0 in any state, go to IDLE the next cycle, clear cnt, hi and o_timeout, hold o_period/o_high, and emit no o_valid.
REQ-021 SHALL register all outputs; o_valid asserts exactly 3 i_clk edges after the edge that first samples i_sig high.
REQ-022 SHALL produce a correct o_period down to a period of 4 i_clk cycles (2 high / 2 low); narrower pulses are undefined.
REQ-023 SHALL never wrap cnt; the timeout bound guarantees this.

Reset
REQ-024 SHALL, while i_reset=0, immediately force state=IDLE, s1=s2=s3=0, cnt=hi=0, o_period=0, o_high=0, o_valid=0, o_timeout=0.
REQ-025 SHALL resume from IDLE on the first i_clk edge after i_reset returns to 1; a reset mid-MEASURE produces no o_valid.

Structure
REQ-026 SHALL place the state encodings (IDLE=2'd0, ARM=2'd1, MEASURE=2'd2) and the default TIMEOUT in shared package period_meter_pkg.
REQ-027 SHALL implement the synchroniser and edge detector (REQ-011) as sub-module sync_edge_detect, with outputs level (s2) and rise.
REQ-028 SHALL keep the state machine and counters in period_meter; target size is 120-250 lines.

Verification (TIMEOUT=1000, i_enable=1 unless stated)
REQ-029 SHALL verify: square wave of period 100 and high 30 -> o_valid pulse at every rise from the second onward, with o_period=100 and o_high=30.
REQ-030 SHALL verify: i_sig held low after a rise -> 1000 cycles after that rise, o_timeout=1, o_period=0, no o_valid; the next rise clears o_timeout.
REQ-031 SHALL verify: period-4 toggle (2 high / 2 low) -> o_period=4, o_high=2.
REQ-032 SHALL verify: i_enable=0 for one cycle mid-MEASURE -> state IDLE, no o_valid, o_period holds; after re-enable the first valid measurement follows the second rise.
REQ-033 SHALL verify: i_reset pulsed low mid-MEASURE (asynchronous to i_clk) -> all outputs 0 with no clock edge; no spurious o_valid after release.
REQ-034 SHALL verify: rise landing in the same cycle as cnt=TIMEOUT-1 -> o_valid with o_period=1000, o_timeout stays 0.
